led_chaser: RTL and testbench

- Parametrised LED pattern generator for the board LED bank, one LED_NUM-bit output register.
- Free-running prescaler advances the pattern one step per period; the period is selectable at runtime.
- Four runtime-selectable modes: rotate left, rotate right, bounce, fill bar. Has run/pause control and status strobes.
- Sits directly behind board clock/reset, drives LED pins; intended as generic replacement for fixed 4-LED chasers.

---
 rtl/led_pkg.sv | 15 +
 rtl/led_step_timer.sv | 44 ++++
 rtl/led_chaser.sv | 124 ++++++++++++
 tb/tb_led_chaser.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared definitions for the LED chaser: mode encodings and the pattern
// state enum. Imported by led_chaser and led_step_timer.
package led_pkg;

  localparam logic [1:0] MODE_ROL    = 2'b00;
  localparam logic [1:0] MODE_ROR    = 2'b01;
  localparam logic [1:0] MODE_BOUNCE = 2'b10;
  localparam logic [1:0] MODE_FILL   = 2'b11;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

endpackage

// File: rtl/led_step_timer.sv
// Free-running prescaler that produces one tick per step period.
// Period P = STEP_CYCLES >> speed; the timer counts 0..P-1 while run = 1.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   run        : 1 = count, 0 = hold timer (no tick)
//   clear      : forces the timer back to 0 (used on a mode change)
//   speed      : period select, each increment halves the period
//   tick       : high in the cycle the timer reaches the end of the period
module led_step_timer
  import led_pkg::*;
#(
  parameter int STEP_CYCLES = 50_000_000,
  parameter int TW          = $clog2(STEP_CYCLES)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic       clear,
  input  logic [1:0] speed,
  output logic       tick
);

  localparam logic [31:0] STEP_U = 32'(STEP_CYCLES);

  logic [TW-1:0] timer;
  logic [31:0]   period_m1;

  assign period_m1 = (STEP_U >> speed) - 32'd1;

  // A >= compare (not ==) so that switching to a shorter period while the
  // timer is already past the new end ticks at once instead of wrapping.
  assign tick = run && (32'(timer) >= period_m1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer <= '0;
    end else if (clear || tick) begin
      timer <= '0;
    end else if (run) begin
      timer <= timer + TW'(1);
    end
  end

endmodule

// File: rtl/led_chaser.sv
// Parametrised LED pattern generator: rotate left, rotate right, bounce and
// fill bar, advanced one step per prescaler period, with run/pause control.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   run        : 1 = advance, 0 = pause (timer and LEDs hold)
//   mode       : 00 rotate left, 01 rotate right, 10 bounce, 11 fill bar
//   speed      : step period = STEP_CYCLES >> speed
//   led        : registered LED drive, 1 = on
//   step       : one-cycle pulse in the cycle led updates
//   wrap       : one-cycle pulse with step when the pattern returns to start
module led_chaser
  import led_pkg::*;
#(
  parameter int LED_NUM     = 4,
  parameter int STEP_CYCLES = 50_000_000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run,
  input  logic [1:0]         mode,
  input  logic [1:0]         speed,
  output logic [LED_NUM-1:0] led,
  output logic               step,
  output logic               wrap
);

  localparam int TW = $clog2(STEP_CYCLES);
  localparam logic [LED_NUM-1:0] LSB = LED_NUM'(1);
  localparam logic [LED_NUM-1:0] MSB = LSB << (LED_NUM - 1);

  state_t             state_q, state_d;
  logic [1:0]         mode_q;
  logic [LED_NUM-1:0] led_d;
  logic               dir_up, dir_d;
  logic               step_d, wrap_d;
  logic               mode_chg;
  logic               tick;
  logic               go_up;

  assign mode_chg = (mode != mode_q);

  led_step_timer #(
    .STEP_CYCLES(STEP_CYCLES),
    .TW         (TW)
  ) u_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .run  (run),
    .clear(mode_chg),
    .speed(speed),
    .tick (tick)
  );

  // Bounce turns around at either end; away from the ends it keeps its
  // direction, so the end bits are shown once per pass.
  assign go_up = dir_up ? !led[LED_NUM-1] : led[0];

  always_comb begin
    state_d = state_q;
    led_d   = led;
    dir_d   = dir_up;
    step_d  = 1'b0;
    wrap_d  = 1'b0;
    if (mode_chg) begin
      // Mode change wins over tick and run: restart from a dark bank.
      state_d = IDLE;
      led_d   = '0;
      dir_d   = 1'b1;
    end else if (tick) begin
      step_d = 1'b1;
      if (state_q == IDLE) begin
        state_d = ACTIVE;
        dir_d   = 1'b1;
        led_d   = (mode_q == MODE_ROR) ? MSB : LSB;
      end else begin
        case (mode_q)
          MODE_ROL: begin
            led_d  = (led << 1) | (led >> (LED_NUM - 1));
            wrap_d = (led_d == LSB);
          end
          MODE_ROR: begin
            led_d  = (led >> 1) | (led << (LED_NUM - 1));
            wrap_d = (led_d == MSB);
          end
          MODE_BOUNCE: begin
            if (LED_NUM == 1) begin
              // Single LED: nowhere to move, every step is a full period.
              wrap_d = 1'b1;
            end else begin
              led_d  = go_up ? (led << 1) : (led >> 1);
              dir_d  = go_up;
              wrap_d = (led_d == LSB);
            end
          end
          MODE_FILL: begin
            // Thermometer grows by one bit per step; full bar goes dark,
            // and the dark state restarts at a single bit.
            led_d  = (&led) ? '0 : ((led << 1) | LSB);
            wrap_d = (led_d == LSB);
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mode_q  <= MODE_ROL;
      led     <= '0;
      dir_up  <= 1'b1;
      step    <= 1'b0;
      wrap    <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode;
      led     <= led_d;
      dir_up  <= dir_d;
      step    <= step_d;
      wrap    <= wrap_d;
    end
  end

endmodule

// File: tb/tb_led_chaser.sv
// Self-checking bench for led_chaser (LED_NUM = 4, STEP_CYCLES = 8).
// The reference model tracks a step index per pattern and derives the LED
// value from it arithmetically.
module tb_led_chaser;

  localparam int N  = 4;
  localparam int SC = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         run = 1'b0;
  logic [1:0]   mode = 2'b00;
  logic [1:0]   speed = 2'b00;
  logic [N-1:0] led;
  logic         step;
  logic         wrap;

  always #5 clk = ~clk;

  led_chaser #(
    .LED_NUM    (N),
    .STEP_CYCLES(SC)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .run  (run),
    .mode (mode),
    .speed(speed),
    .led  (led),
    .step (step),
    .wrap (wrap)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  int           m_cnt;     // run cycles elapsed in the current period
  int           m_idx;     // steps taken since the pattern started
  bit           m_active;
  logic [1:0]   m_mq;
  logic [N-1:0] m_led;
  bit           m_step, m_wrap;

  function automatic int period_of(input logic [1:0] md);
    case (md)
      2'b10:   return 2 * N - 2;
      2'b11:   return N + 1;
      default: return N;
    endcase
  endfunction

  function automatic logic [N-1:0] pat(input logic [1:0] md, input int idx);
    int p, k;
    case (md)
      2'b00: return N'(1 << (idx % N));
      2'b01: return N'(1 << (N - 1 - (idx % N)));
      2'b10: begin
        p = idx % (2 * N - 2);
        return N'(1 << ((p < N) ? p : (2 * N - 2 - p)));
      end
      default: begin
        k = (idx % (N + 1)) + 1;
        return (k == N + 1) ? '0 : N'((1 << k) - 1);
      end
    endcase
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_idx = 0; m_active = 0; m_mq = 2'b00;
    m_led = '0; m_step = 0; m_wrap = 0;
  endtask

  task automatic model_edge();
    int p;
    if (!rst_n) begin
      model_reset();
    end else if (mode != m_mq) begin
      m_led = '0; m_active = 0; m_cnt = 0; m_step = 0; m_wrap = 0;
      m_mq = mode;
    end else begin
      p = SC >> speed;
      m_step = 0; m_wrap = 0;
      if (run && m_cnt >= p - 1) begin
        m_cnt = 0;
        m_step = 1;
        if (!m_active) begin
          m_active = 1;
          m_idx = 0;
        end else begin
          m_idx++;
          m_wrap = (m_idx % period_of(m_mq)) == 0;
        end
        m_led = pat(m_mq, m_idx);
      end else if (run) begin
        m_cnt++;
      end
      m_mq = mode;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    check("led", 32'(led), 32'(m_led));
    check("step", 32'(step), 32'(m_step));
    check("wrap", 32'(wrap), 32'(m_wrap));
  endtask

  int guard;

  initial begin
    model_reset();
    run = 1'b1; mode = 2'b00; speed = 2'b00;
    #12;
    check("rst_led", 32'(led), 32'd0);
    check("rst_step", 32'(step), 32'd0);
    check("rst_wrap", 32'(wrap), 32'd0);
    rst_n = 1'b1;

    // Rotate left: dark for one period, then 0001 .. 1000, 0001 with wrap
    repeat (7) cyc();
    check("rol_dark", 32'(led), 32'd0);
    cyc();
    check("rol_first", 32'(led), 32'b0001);
    check("rol_first_wrap", 32'(wrap), 32'd0);
    repeat (32) cyc();
    check("rol_wrap_led", 32'(led), 32'b0001);
    check("rol_wrap", 32'(wrap), 32'd1);

    // Bounce: seven steps after the mode change, last one wraps
    mode = 2'b10;
    cyc();
    check("bnc_clear", 32'(led), 32'd0);
    repeat (56) cyc();
    check("bnc_wrap_led", 32'(led), 32'b0001);
    check("bnc_wrap", 32'(wrap), 32'd1);

    // Fill bar: 0001 0011 0111 1111 0000 0001(wrap)
    mode = 2'b11;
    cyc();
    repeat (32) cyc();
    check("fill_full", 32'(led), 32'b1111);
    repeat (8) cyc();
    check("fill_dark", 32'(led), 32'b0000);
    repeat (8) cyc();
    check("fill_wrap_led", 32'(led), 32'b0001);
    check("fill_wrap", 32'(wrap), 32'd1);

    // Pause mid-step, then resume
    repeat (3) cyc();
    run = 1'b0;
    repeat (20) cyc();
    check("pause_hold", 32'(led), 32'b0001);
    run = 1'b1;
    repeat (12) cyc();

    // Fast speed
    speed = 2'd2;
    repeat (20) cyc();

    // Speed 0 -> 3 with the timer at 5
    speed = 2'd0;
    guard = 0;
    while (m_cnt != 5 && guard < 50) begin cyc(); guard++; end
    check("spd_wait", 32'(m_cnt), 32'd5);
    speed = 2'd3;
    cyc();
    check("spd_tick0", 32'(step), 32'd1);
    cyc();
    check("spd_tick1", 32'(step), 32'd1);
    speed = 2'd0;

    // Mode change rotate left -> rotate right at led = 0100
    mode = 2'b00;
    guard = 0;
    while (m_led != 4'b0100 && guard < 200) begin cyc(); guard++; end
    check("rol_reach", 32'(led), 32'b0100);
    mode = 2'b01;
    cyc();
    check("ror_clear", 32'(led), 32'd0);
    repeat (8) cyc();
    check("ror_first", 32'(led), 32'b1000);

    // Asynchronous reset mid-step
    repeat (3) cyc();
    rst_n = 1'b0;
    #1;
    check("arst_led", 32'(led), 32'd0);
    check("arst_step", 32'(step), 32'd0);
    check("arst_wrap", 32'(wrap), 32'd0);
    model_reset();
    repeat (3) cyc();
    rst_n = 1'b1;

    // Randomized operation against the model
    for (int i = 0; i < 4000; i++) begin
      cyc();
      if ($urandom_range(0, 99) < 2) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 99) < 4) run = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 99) < 3) speed = 2'($urandom_range(0, 3));
      if (rst_n && $urandom_range(0, 599) == 0) begin
        rst_n = 1'b0;
        #1;
        check("rnd_arst_led", 32'(led), 32'd0);
        model_reset();
      end else if (!rst_n && $urandom_range(0, 2) == 0) begin
        rst_n = 1'b1;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
